// File: rtl/pll_pkg.sv
// Shared definitions for the ADPLL start-up sequencer: state encoding,
// default timing constants and a saturating counter helper.
package pll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_PLL = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

    localparam int DEF_RST_CYCLES  = 4;
    localparam int DEF_LOCK_STABLE = 16;
    localparam int DEF_TIMEOUT     = 1023;
    localparam int DEF_MAX_RETRY   = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/pll_seq.sv
// ADPLL start-up/relock sequencer: applies a multiplier, pulses the PLL reset,
// waits for a stable lock with bounded retries and tracks lock losses.
module pll_seq
    import pll_pkg::*;
#(
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] m_req,
    input  logic       lock_in,
    output logic       ack,
    output logic       cfg_err,
    output logic [2:0] m_out,
    output logic       pll_reset,
    output logic       busy,
    output logic       clk_ok,
    output logic       err,
    output logic [7:0] lost_cnt
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int YW = $clog2(MAX_RETRY + 1);

    pll_state_t    r_state;
    logic [RW-1:0] r_rst_cnt;
    logic [SW-1:0] r_stab_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic [YW-1:0] r_retry;
    logic          r_ack;
    logic          r_cfg_err;
    logic [2:0]    r_m_out;
    logic          r_pll_reset;
    logic          r_busy;
    logic          r_clk_ok;
    logic          r_err;
    logic [7:0]    r_lost_cnt;

    logic          w_lock_s;
    logic          w_accept;
    logic          w_legal;
    logic [YW-1:0] w_retry_inc;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (lock_in),
        .q     (w_lock_s)
    );

    // The ack pulse itself blocks re-acceptance, since the requester only drops req after seeing it.
    assign w_accept    = req && !r_ack &&
                         (r_state == ST_IDLE || r_state == ST_LOCKED || r_state == ST_FAIL);
    assign w_legal     = (m_req != 3'd0);
    assign w_retry_inc = r_retry + YW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rst_cnt   <= '0;
            r_stab_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_retry     <= '0;
            r_ack       <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_m_out     <= 3'd1;
            r_pll_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_clk_ok    <= 1'b0;
            r_err       <= 1'b0;
            r_lost_cnt  <= 8'd0;
        end else begin
            r_ack     <= 1'b0;
            r_cfg_err <= 1'b0;
            if (w_accept && !w_legal) begin
                r_ack     <= 1'b1;
                r_cfg_err <= 1'b1;
            end else if (w_accept) begin
                r_ack       <= 1'b1;
                r_m_out     <= m_req;
                r_pll_reset <= 1'b1;
                r_state     <= ST_RESET_PLL;
                r_rst_cnt   <= '0;
                r_stab_cnt  <= '0;
                r_tmo_cnt   <= '0;
                r_retry     <= '0;
                r_lost_cnt  <= 8'd0;
                r_busy      <= 1'b1;
                r_clk_ok    <= 1'b0;
                r_err       <= 1'b0;
            end else begin
                case (r_state)
                    ST_RESET_PLL: begin
                        if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
                            r_state     <= ST_WAIT_LOCK;
                            r_pll_reset <= 1'b0;
                            r_stab_cnt  <= '0;
                            r_tmo_cnt   <= '0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + RW'(1);
                        end
                    end
                    // Lock is tested before timeout so a coincident finish counts as locked.
                    ST_WAIT_LOCK: begin
                        if (w_lock_s && r_stab_cnt == SW'(LOCK_STABLE - 1)) begin
                            r_state  <= ST_LOCKED;
                            r_busy   <= 1'b0;
                            r_clk_ok <= 1'b1;
                        end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
                            r_retry     <= w_retry_inc;
                            r_rst_cnt   <= '0;
                            r_stab_cnt  <= '0;
                            r_tmo_cnt   <= '0;
                            r_pll_reset <= 1'b1;
                            if (w_retry_inc < YW'(MAX_RETRY)) begin
                                r_state <= ST_RESET_PLL;
                            end else begin
                                r_state <= ST_FAIL;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end
                        end else begin
                            r_tmo_cnt  <= r_tmo_cnt + TW'(1);
                            r_stab_cnt <= w_lock_s ? r_stab_cnt + SW'(1) : '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_lock_s) begin
                            r_state    <= ST_WAIT_LOCK;
                            r_busy     <= 1'b1;
                            r_clk_ok   <= 1'b0;
                            r_stab_cnt <= '0;
                            r_tmo_cnt  <= '0;
                            r_lost_cnt <= sat_inc8(r_lost_cnt);
                        end else begin
                            r_state <= ST_LOCKED;
                        end
                    end
                    ST_IDLE, ST_FAIL: begin
                        r_state <= r_state;
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_pll_reset <= 1'b1;
                        r_busy      <= 1'b0;
                        r_clk_ok    <= 1'b0;
                        r_err       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ack       = r_ack;
    assign cfg_err   = r_cfg_err;
    assign m_out     = r_m_out;
    assign pll_reset = r_pll_reset;
    assign busy      = r_busy;
    assign clk_ok    = r_clk_ok;
    assign err       = r_err;
    assign lost_cnt  = r_lost_cnt;

endmodule

// File: tb/tb_pll_seq.sv
// Directed bench for pll_seq with RST_CYCLES=2, LOCK_STABLE=4, TIMEOUT=20, MAX_RETRY=2.
module tb_pll_seq;
    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic [2:0] m_req;
    logic       lock_in;
    logic       ack;
    logic       cfg_err;
    logic [2:0] m_out;
    logic       pll_reset;
    logic       busy;
    logic       clk_ok;
    logic       err;
    logic [7:0] lost_cnt;

    int checks = 0;
    int errors = 0;

    pll_seq #(
        .RST_CYCLES  (2),
        .LOCK_STABLE (4),
        .TIMEOUT     (20),
        .MAX_RETRY   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .m_req     (m_req),
        .lock_in   (lock_in),
        .ack       (ack),
        .cfg_err   (cfg_err),
        .m_out     (m_out),
        .pll_reset (pll_reset),
        .busy      (busy),
        .clk_ok    (clk_ok),
        .err       (err),
        .lost_cnt  (lost_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Outputs are {ack, cfg_err, pll_reset, busy, clk_ok, err} in all vector checks below.
    task automatic test_reset();
        logic [5:0] exp_v;
        exp_v = 6'b001000;
        @(negedge clk);
        checks++;
        if ({ack, cfg_err, pll_reset, busy, clk_ok, err} !== exp_v || m_out !== 3'd1 || lost_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: flags=%b m_out=%0d lost=%0d expected flags=%b m_out=1 lost=0",
                     {ack, cfg_err, pll_reset, busy, clk_ok, err}, m_out, lost_cnt, exp_v);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack, cfg_err, pll_reset, busy, clk_ok, err} !== exp_v) begin
            errors++;
            $display("FAIL idle_hold: flags=%b expected %b", {ack, cfg_err, pll_reset, busy, clk_ok, err}, exp_v);
        end
    endtask

    task automatic test_cfg_err();
        lock_in = 1'b1;
        req = 1'b1;
        m_req = 3'd0;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if ({ack, cfg_err, pll_reset, busy, clk_ok, err} !== 6'b111000 || m_out !== 3'd1) begin
            errors++;
            $display("FAIL cfg_err_pulse: flags=%b m_out=%0d expected flags=111000 m_out=1",
                     {ack, cfg_err, pll_reset, busy, clk_ok, err}, m_out);
        end
        @(negedge clk);
        checks++;
        if ({ack, cfg_err, pll_reset, busy, clk_ok, err} !== 6'b001000 || m_out !== 3'd1) begin
            errors++;
            $display("FAIL cfg_err_after: flags=%b m_out=%0d expected flags=001000 m_out=1",
                     {ack, cfg_err, pll_reset, busy, clk_ok, err}, m_out);
        end
    endtask

    task automatic test_lock();
        logic [5:0] exp_v;
        req = 1'b1;
        m_req = 3'd5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) req = 1'b0;
            exp_v = {(k == 0), 1'b0, (k < 2), (k < 6), (k >= 6), 1'b0};
            checks++;
            if ({ack, cfg_err, pll_reset, busy, clk_ok, err} !== exp_v || m_out !== 3'd5) begin
                errors++;
                $display("FAIL lock_seq[%0d]: flags=%b m_out=%0d expected flags=%b m_out=5",
                         k, {ack, cfg_err, pll_reset, busy, clk_ok, err}, m_out, exp_v);
            end
        end
    endtask

    task automatic test_loss();
        logic exp_ok;
        logic [7:0] exp_lost;
        lock_in = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            exp_ok = !(n >= 3 && n <= 8);
            exp_lost = (n >= 3) ? 8'd1 : 8'd0;
            checks++;
            if (clk_ok !== exp_ok || pll_reset !== 1'b0 || lost_cnt !== exp_lost) begin
                errors++;
                $display("FAIL loss_seq[%0d]: clk_ok=%b pll_reset=%b lost=%0d expected clk_ok=%b pll_reset=0 lost=%0d",
                         n, clk_ok, pll_reset, lost_cnt, exp_ok, exp_lost);
            end
            if (n == 3) lock_in = 1'b1;
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            lock_in = 1'b0;
            @(negedge clk);
            lock_in = 1'b1;
            repeat (9) @(negedge clk);
        end
        checks++;
        if (lost_cnt !== 8'd255 || clk_ok !== 1'b1) begin
            errors++;
            $display("FAIL lost_saturate: lost=%0d clk_ok=%b expected lost=255 clk_ok=1", lost_cnt, clk_ok);
        end
    endtask

    task automatic test_back_to_back();
        logic got;
        logic prev_ok;
        lock_in = 1'b0;
        repeat (2) @(negedge clk);
        req = 1'b1;
        m_req = 3'd7;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if ({ack, pll_reset, busy, clk_ok} !== 4'b1110 || m_out !== 3'd7 || lost_cnt !== 8'd0) begin
            errors++;
            $display("FAIL req_vs_drop: ack/pr/busy/ok=%b m_out=%0d lost=%0d expected 1110 m_out=7 lost=0",
                     {ack, pll_reset, busy, clk_ok}, m_out, lost_cnt);
        end
        repeat (3) @(negedge clk);
        req = 1'b1;
        m_req = 3'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL held_req_wait[%0d]: ack=%b busy=%b expected ack=0 busy=1", i, ack, busy);
            end
        end
        lock_in = 1'b1;
        got = 1'b0;
        prev_ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                got = 1'b1;
                break;
            end
            prev_ok = clk_ok;
        end
        req = 1'b0;
        checks++;
        if (got !== 1'b1 || prev_ok !== 1'b1 || m_out !== 3'd2) begin
            errors++;
            $display("FAIL held_req_ack: got_ack=%b clk_ok_before=%b m_out=%0d expected 1 1 2", got, prev_ok, m_out);
        end
    endtask

    task automatic test_reset_mid();
        lock_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || pll_reset !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_wait: busy=%b pll_reset=%b expected busy=1 pll_reset=0", busy, pll_reset);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack, cfg_err, pll_reset, busy, clk_ok, err} !== 6'b001000 || m_out !== 3'd1 || lost_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: flags=%b m_out=%0d lost=%0d expected flags=001000 m_out=1 lost=0",
                     {ack, cfg_err, pll_reset, busy, clk_ok, err}, m_out, lost_cnt);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fail();
        logic [5:0] exp_v;
        logic f;
        logic pr;
        req = 1'b1;
        m_req = 3'd5;
        for (int k = 0; k < 47; k++) begin
            @(negedge clk);
            if (k == 0) req = 1'b0;
            f = (k >= 44);
            pr = (k <= 1) || (k == 22) || (k == 23) || f;
            exp_v = {(k == 0), 1'b0, pr, !f, 1'b0, f};
            checks++;
            if ({ack, cfg_err, pll_reset, busy, clk_ok, err} !== exp_v) begin
                errors++;
                $display("FAIL fail_seq[%0d]: flags=%b expected %b", k, {ack, cfg_err, pll_reset, busy, clk_ok, err}, exp_v);
            end
        end
        req = 1'b1;
        m_req = 3'd3;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if ({ack, cfg_err, pll_reset, busy, clk_ok, err} !== 6'b101100 || m_out !== 3'd3) begin
            errors++;
            $display("FAIL fail_restart: flags=%b m_out=%0d expected flags=101100 m_out=3",
                     {ack, cfg_err, pll_reset, busy, clk_ok, err}, m_out);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0;
        m_req = 3'd0;
        lock_in = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_cfg_err();
        test_lock();
        test_loss();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        test_fail();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_seq.md
PLL_SEQ -- requirements
Module: pll_seq

Interface
REQ-001 Parameter RST_CYCLES, default 4: REF cycles pll_reset is held per (re)start attempt.
REQ-002 Parameter LOCK_STABLE, default 16: consecutive synchronized-LOCK cycles required to declare lock.
REQ-003 Parameter TIMEOUT, default 1023: REF cycles allowed in WAIT_LOCK per attempt.
REQ-004 Parameter MAX_RETRY, default 3: attempts per request before FAIL.
REQ-005 clk  in  1  reference clock; the same net as the ADPLL REF_CLK.
REQ-006 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-007 req  in  1  level request to (re)configure; held by requester until ack.
REQ-008 m_req  in  3  requested ADPLL multiplier, legal 1..7.
REQ-009 lock_in  in  1  ADPLL LOCK, asynchronous to clk.
REQ-010 ack  out  1  one-cycle pulse: request consumed.
REQ-011 cfg_err  out  1  one-cycle pulse with ack when m_req==0.
REQ-012 m_out  out  3  registered multiplier to ADPLL M.
REQ-013 pll_reset  out  1  registered reset to ADPLL RESET.
REQ-014 busy  out  1  high in RESET_PLL or WAIT_LOCK.
REQ-015 clk_ok  out  1  high only in LOCKED.
REQ-016 err  out  1  high only in FAIL.
REQ-017 lost_cnt  out  8  saturating count of lock losses since last accepted request.

Function
REQ-018 lock_in SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s.
REQ-019 States SHALL be IDLE, RESET_PLL, WAIT_LOCK, LOCKED, FAIL.
REQ-020 req SHALL be eligible for acceptance only in IDLE, LOCKED, FAIL; elsewhere it stays pending with no ack.
REQ-021 An accepted req with m_req==0 SHALL produce ack=1 and cfg_err=1 next cycle, with no change to state or other outputs.
REQ-022 An accepted legal req at cycle t SHALL give, at t+1: ack=1, m_out=m_req, pll_reset=1, state RESET_PLL, retry count 0, lost_cnt 0.
REQ-023 RESET_PLL SHALL hold pll_reset=1 for exactly RST_CYCLES cycles, then enter WAIT_LOCK with pll_reset=0 and timers cleared.
REQ-024 WAIT_LOCK SHALL count consecutive lock_s=1 cycles; a lock_s=0 cycle clears the count.
REQ-025 When the consecutive count reaches LOCK_STABLE, the FSM SHALL enter LOCKED with clk_ok=1 next cycle.
REQ-026 If TIMEOUT cycles elapse in WAIT_LOCK without lock, retry count SHALL increment. If it is then below MAX_RETRY, the FSM SHALL return to RESET_PLL; otherwise it SHALL enter FAIL.
REQ-027 Lock completing on the same cycle as timeout SHALL take the lock path.
REQ-028 In LOCKED, lock_s=0 SHALL move to WAIT_LOCK with clk_ok=0 next cycle and lost_cnt+1, saturating at 255, with no pll_reset pulse.
REQ-029 In LOCKED, a req and a lock_s drop in the same cycle SHALL give req priority; lost_cnt is not incremented.
REQ-030 FAIL SHALL hold pll_reset=1 and err=1 until a legal req or reset.
REQ-031 m_out SHALL change only on legal acceptance.
REQ-032 Counters SHALL be sized by $clog2 of their parameters and SHALL never wrap.

Reset
REQ-033 Reset SHALL give state IDLE, m_out=1, pll_reset=1, ack=cfg_err=busy=clk_ok=err=0, lost_cnt=0, all counters and synchronizer flops 0.
REQ-034 Reset asserted mid-sequence SHALL override all activity on that edge; a pending req is re-evaluated only after reset deasserts.
REQ-035 IDLE SHALL keep pll_reset=1 until the first legal request.

Structure
REQ-036 The state enum encoding and default parameter constants SHALL reside in shared package pll_pkg.
REQ-037 The synchronizer SHALL be sub-module sync2 (clk, reset, d, q); the FSM and counters stay in pll_seq.

Verification (bench params RST_CYCLES=2, LOCK_STABLE=4, TIMEOUT=20, MAX_RETRY=2)
REQ-038 Reset, then req=1, m_req=5 -> ack 1 cycle later; m_out=5; pll_reset high exactly 2 cycles. lock_in held 1 -> clk_ok rises 2+4 cycles after sync latency.
REQ-039 m_req=0 in IDLE -> ack and cfg_err pulse together; m_out stays 1; state IDLE.
REQ-040 lock_in held 0 -> two attempts of 2+20 cycles each, then err=1 and pll_reset=1; a new req with m_req=3 restarts.
REQ-041 In LOCKED, 3-cycle lock_in drop -> clk_ok=0, lost_cnt=1, no pll_reset; relock after 4 stable cycles. Forcing 300 drops -> lost_cnt saturates at 255.
REQ-042 Simultaneous req (m_req=7) and lock drop in LOCKED -> ack, m_out=7, lost_cnt=0. A req held during WAIT_LOCK -> no ack until LOCKED.
REQ-043 Reset asserted in WAIT_LOCK -> next cycle matches REQ-033 values.
